alu_top: RTL and testbench
==========================

Name: alu_top

Overview:
- Board-level ALU wrapper: a single switch bank is loaded into operand A, operand B or the opcode register by three push-buttons.
- The internal combinational ALU result is registered and driven to LEDs.
- Contains the button edge detect, the three operand/opcode registers, the ALU, and the output register.

Parameters:
NB_DATA, 8, width of switches, operands, opcode and result
NB_BUTTONS, 3, number of load buttons (bit0=A, bit1=B, bit2=opcode)

Ports:
i_clock  input  1  system clock, all logic on rising edge
i_reset  input  1  synchronous, active-low reset
i_switches  input  NB_DATA  data/opcode value to load
i_buttons  input  NB_BUTTONS  load strobes, active-high, level from board
o_resultado  output  NB_DATA (signed)  registered ALU result

Behaviour:
- One clock; reset is synchronous and active-low: i_reset sampled low at a rising edge clears A, B, OP, button-history regs and o_resultado to 0.
- Reset has priority over any button activity in the same cycle. Reset mid-operation discards all loaded values.
- Edge detect: btn_q <= i_buttons each cycle; load pulse = i_buttons & ~btn_q. A held button loads exactly once per press.
- Loads on a pulse:
  - bit0: A <= i_switches
  - bit1: B <= i_switches
  - bit2: OP <= i_switches
- Simultaneous pulses each load their own register from the same switch value.
- ALU (combinational on A, B, OP):
  - ADD 0x20: A+B, modulo 2^NB_DATA, carry dropped.
  - SUB 0x22: A-B, two's complement wrap.
  - AND 0x24: A&B.
  - OR 0x25: A|B.
  - XOR 0x26: A^B.
  - NOR 0x27: ~(A|B).
  - SRA 0x03: A arithmetic right shift by unsigned B. If B >= NB_DATA, result is all copies of A's sign bit.
  - SRL 0x02: A logical right shift by unsigned B. If B >= NB_DATA, result is 0.
  - Any other OP (including reset value 0x00): result 0.
- o_resultado <= ALU result every cycle (not only on loads).
- Latency: a button rises at edge n, the pulse is seen and the register loads at edge n+1, and o_resultado reflects the new value at edge n+2.
- Switch changes without a button press have no effect.

Optional Feature:
BUTTON_SYNC_EN
- Defined: i_buttons passes through a 2-flop synchronizer before the edge detect. Edge detect runs on the synchronized bits. Load and result latency grow by 2 cycles (result at n+4). Synchronizer flops reset to 0.
- Undefined: edge detect samples i_buttons directly, with the latency stated above.

Test Plan:
- Reset: i_reset=0 for 2 cycles with random switches/buttons -> o_resultado=0x00. After release with no presses, stays 0x00.
- SRA/SRL: load A=0x80, B=0x03, OP=0x03 -> o_resultado=0xF0. Then load OP=0x02 -> 0x10.
- Arithmetic/logic with A=0x5A, B=0x3C:
  - ADD -> 0x96
  - SUB -> 0x1E
  - AND -> 0x18
  - OR -> 0x7E
  - XOR -> 0x66
  - NOR -> 0x81
  - Then A=0xFF, B=0x01, ADD -> 0x00 (wrap).
- Held button: hold bit0 for 20 cycles while switches change 0x11->0x22 after the first edge -> A stays 0x11, so A+B with B=0 gives 0x11.
- Boundary and defaults:
  - A=0x81, B=0x09, SRA -> 0xFF; SRL -> 0x00.
  - OP=0x55 (undefined) -> 0x00.
- Reset mid-operation: after a valid ADD result, assert reset one cycle -> output 0x00, A/B/OP cleared, and the next ADD with only B=0x07 loaded -> 0x07.

Source files
------------

// File: rtl/alu_top.sv
// alu_top: board-level ALU wrapper.
// One switch bank is loaded into operand A, operand B or the opcode register
// by three push-buttons (bit0=A, bit1=B, bit2=opcode). Each press loads once,
// on the rising edge of the button level. The combinational ALU result is
// registered every cycle and driven to the LEDs.
//
// Optional build macro: BUTTON_SYNC_EN
//   defined   - buttons pass through a 2-flop synchronizer before edge detect,
//               so loads and results land two cycles later.
//   undefined - edge detect samples i_buttons directly.
module alu_top #(
   parameter int NB_DATA    = 8,
   parameter int NB_BUTTONS = 3
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic [NB_DATA-1:0]        i_switches,
   input  logic [NB_BUTTONS-1:0]     i_buttons,
   output logic signed [NB_DATA-1:0] o_resultado
);

   // Opcode encodings (MIPS funct-style values).
   localparam logic [NB_DATA-1:0] OP_SRL = NB_DATA'(8'h02);
   localparam logic [NB_DATA-1:0] OP_SRA = NB_DATA'(8'h03);
   localparam logic [NB_DATA-1:0] OP_ADD = NB_DATA'(8'h20);
   localparam logic [NB_DATA-1:0] OP_SUB = NB_DATA'(8'h22);
   localparam logic [NB_DATA-1:0] OP_AND = NB_DATA'(8'h24);
   localparam logic [NB_DATA-1:0] OP_OR  = NB_DATA'(8'h25);
   localparam logic [NB_DATA-1:0] OP_XOR = NB_DATA'(8'h26);
   localparam logic [NB_DATA-1:0] OP_NOR = NB_DATA'(8'h27);

   // Shift amounts at or beyond this value shift every data bit out.
   localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

   // Button indices inside i_buttons.
   localparam int BTN_A  = 0;
   localparam int BTN_B  = 1;
   localparam int BTN_OP = 2;

   logic [NB_BUTTONS-1:0]     btn_in;
   logic [NB_BUTTONS-1:0]     btn_q;
   logic [NB_BUTTONS-1:0]     load_pulse;
   logic signed [NB_DATA-1:0] reg_a;
   logic signed [NB_DATA-1:0] reg_b;
   logic [NB_DATA-1:0]        reg_op;
   logic signed [NB_DATA-1:0] alu_result;

   // Arithmetic right shift; oversized amounts leave only sign copies.
   function automatic logic signed [NB_DATA-1:0] shift_right_arith(
      input logic signed [NB_DATA-1:0] value,
      input logic [NB_DATA-1:0]        amount
   );
      if (amount >= SHIFT_LIMIT)
         return {NB_DATA{value[NB_DATA-1]}};
      else
         return value >>> amount;
   endfunction

   // Logical right shift; oversized amounts clear the result.
   function automatic logic signed [NB_DATA-1:0] shift_right_logic(
      input logic signed [NB_DATA-1:0] value,
      input logic [NB_DATA-1:0]        amount
   );
      logic [NB_DATA-1:0] raw;
      raw = value;
      if (amount >= SHIFT_LIMIT)
         return '0;
      else
         return raw >> amount;
   endfunction

`ifdef BUTTON_SYNC_EN
   logic [NB_BUTTONS-1:0] btn_sync_p0;
   logic [NB_BUTTONS-1:0] btn_sync_p1;

   // Two-flop synchronizer for the asynchronous board buttons.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         btn_sync_p0 <= '0;
         btn_sync_p1 <= '0;
      end else begin
         btn_sync_p0 <= i_buttons;
         btn_sync_p1 <= btn_sync_p0;
      end
   end

   assign btn_in = btn_sync_p1;
`else
   assign btn_in = i_buttons;
`endif

   // Button history for rising-edge detection.
   always_ff @(posedge i_clock) begin
      if (!i_reset)
         btn_q <= '0;
      else
         btn_q <= btn_in;
   end

   // A held button produces a single one-cycle pulse.
   assign load_pulse = btn_in & ~btn_q;

   // Operand and opcode registers, each loaded by its own pulse.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         reg_a  <= '0;
         reg_b  <= '0;
         reg_op <= '0;
      end else begin
         if (load_pulse[BTN_A])
            reg_a <= i_switches;
         if (load_pulse[BTN_B])
            reg_b <= i_switches;
         if (load_pulse[BTN_OP])
            reg_op <= i_switches;
      end
   end

   // Combinational ALU; unknown opcodes (including the reset value) give 0.
   always_comb begin
      alu_result = '0;
      case (reg_op)
         OP_ADD:  alu_result = reg_a + reg_b;
         OP_SUB:  alu_result = reg_a - reg_b;
         OP_AND:  alu_result = reg_a & reg_b;
         OP_OR:   alu_result = reg_a | reg_b;
         OP_XOR:  alu_result = reg_a ^ reg_b;
         OP_NOR:  alu_result = ~(reg_a | reg_b);
         OP_SRA:  alu_result = shift_right_arith(reg_a, reg_b);
         OP_SRL:  alu_result = shift_right_logic(reg_a, reg_b);
         default: alu_result = '0;
      endcase
   end

   // Result register refreshed every cycle, not only on loads.
   always_ff @(posedge i_clock) begin
      if (!i_reset)
         o_resultado <= '0;
      else
         o_resultado <= alu_result;
   end

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: self-checking bench for alu_top.
// Expected LED values are pushed to a scoreboard queue when a load sequence
// is driven and popped once the result has had time to reach o_resultado.
module tb_alu_top;

`ifdef BUTTON_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] sw;
   logic [2:0] btn;
   logic signed [7:0] res;

   logic [7:0] exp_q[$];
   logic [7:0] expv;
   logic [7:0] got;
   int checks;
   int fails;

   alu_top #(.NB_DATA(8), .NB_BUTTONS(3)) dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_switches (sw),
      .i_buttons  (btn),
      .o_resultado(res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b0;
      btn = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // One-cycle press of the buttons in mask with switches at val.
   task automatic press(input logic [2:0] mask, input logic [7:0] val);
      @(negedge clk);
      sw  = val;
      btn = mask;
      @(negedge clk);
      btn = '0;
   endtask

   task automatic settle;
      repeat (LAT + 1) @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sw  = 8'($urandom);
         btn = 3'($urandom);
         @(negedge clk);
      end
      exp_q.push_back(8'h00);
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL reset_held: got %h expected %h", got, expv);
      end
      btn = '0;
      rst = 1'b1;
      exp_q.push_back(8'h00);
      repeat (6) @(negedge clk);
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL reset_idle: got %h expected %h", got, expv);
      end
   endtask

   task automatic test_shift;
      press(3'b001, 8'h80);
      press(3'b010, 8'h03);
      press(3'b100, 8'h03);
      exp_q.push_back(8'hF0);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL sra_80_3: got %h expected %h", got, expv);
      end
      press(3'b100, 8'h02);
      exp_q.push_back(8'h10);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL srl_80_3: got %h expected %h", got, expv);
      end
   endtask

   task automatic test_arith;
      logic [7:0] ops  [6];
      logic [7:0] exps [6];
      ops  = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};
      exps = '{8'h96, 8'h1E, 8'h18, 8'h7E, 8'h66, 8'h81};
      press(3'b001, 8'h5A);
      press(3'b010, 8'h3C);
      for (int i = 0; i < 6; i++) begin
         press(3'b100, ops[i]);
         exp_q.push_back(exps[i]);
         settle();
         got = res; expv = exp_q.pop_front(); checks++;
         if (got !== expv) begin
            fails++;
            $display("FAIL arith_op_%h: got %h expected %h", ops[i], got, expv);
         end
      end
      press(3'b001, 8'hFF);
      press(3'b010, 8'h01);
      press(3'b100, 8'h20);
      exp_q.push_back(8'h00);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL add_wrap: got %h expected %h", got, expv);
      end
   endtask

   task automatic test_held;
      do_reset();
      press(3'b100, 8'h20);
      @(negedge clk);
      sw  = 8'h11;
      btn = 3'b001;
      repeat (LAT - 1) @(negedge clk);
      sw = 8'h22;
      repeat (20 - (LAT - 1)) @(negedge clk);
      btn = '0;
      exp_q.push_back(8'h11);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL held_button: got %h expected %h", got, expv);
      end
      sw = 8'h33;
      exp_q.push_back(8'h11);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL switch_no_press: got %h expected %h", got, expv);
      end
   endtask

   task automatic test_boundary;
      logic [7:0] bv  [5];
      logic [7:0] opv [5];
      logic [7:0] exps[5];
      bv   = '{8'h09, 8'h09, 8'h08, 8'h07, 8'h07};
      opv  = '{8'h03, 8'h02, 8'h03, 8'h03, 8'h02};
      exps = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h01};
      press(3'b001, 8'h81);
      for (int i = 0; i < 5; i++) begin
         press(3'b010, bv[i]);
         press(3'b100, opv[i]);
         exp_q.push_back(exps[i]);
         settle();
         got = res; expv = exp_q.pop_front(); checks++;
         if (got !== expv) begin
            fails++;
            $display("FAIL shift_b%h_op%h: got %h expected %h", bv[i], opv[i], got, expv);
         end
      end
      press(3'b100, 8'h55);
      exp_q.push_back(8'h00);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL undefined_op: got %h expected %h", got, expv);
      end
   endtask

   task automatic test_latency;
      press(3'b001, 8'h01);
      press(3'b010, 8'h00);
      press(3'b100, 8'h20);
      settle();
      @(negedge clk);
      sw  = 8'h02;
      btn = 3'b001;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      @(negedge clk);
      btn = '0;
      repeat (LAT - 2) @(negedge clk);
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL latency_early: got %h expected %h", got, expv);
      end
      @(negedge clk);
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL latency_ontime: got %h expected %h", got, expv);
      end
   endtask

   task automatic test_simultaneous;
      do_reset();
      press(3'b100, 8'h20);
      press(3'b011, 8'h05);
      exp_q.push_back(8'h0A);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL simult_ab: got %h expected %h", got, expv);
      end
      press(3'b111, 8'h24);
      exp_q.push_back(8'h24);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL simult_all: got %h expected %h", got, expv);
      end
   endtask

   task automatic test_reset_mid;
      press(3'b001, 8'h5A);
      press(3'b010, 8'h3C);
      press(3'b100, 8'h20);
      exp_q.push_back(8'h96);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL mid_pre_add: got %h expected %h", got, expv);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back(8'h00);
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL mid_reset_out: got %h expected %h", got, expv);
      end
      press(3'b010, 8'h07);
      exp_q.push_back(8'h00);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL mid_op_cleared: got %h expected %h", got, expv);
      end
      press(3'b100, 8'h20);
      exp_q.push_back(8'h07);
      settle();
      got = res; expv = exp_q.pop_front(); checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL mid_add_b_only: got %h expected %h", got, expv);
      end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst    = 1'b0;
      sw     = '0;
      btn    = '0;
      test_reset();
      test_shift();
      test_arith();
      test_held();
      test_boundary();
      test_latency();
      test_simultaneous();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
